// File: rtl/seq_controller.sv
// seq_controller: tiny accumulator machine sequencer. Fetches instruction
// words over a request/acknowledge memory port, executes load/ALU/jump/write
// instructions, and halts on HLT or on a memory acknowledge timeout.
module seq_controller #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic [1:0]        flags,
    output logic              halted,
    output logic              fault
);

    // The opcode occupies the top nibble, so the word must hold it plus an operand.
    if (DATA_W < ADDR_W + 4) begin : g_width_check
        $error("seq_controller: DATA_W must be at least ADDR_W+4");
    end
    if (MAX_WAIT < 1) begin : g_wait_check
        $error("seq_controller: MAX_WAIT must be at least 1");
    end

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_JZ  = 4'b0011;
    localparam logic [3:0] OP_WRT = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        MEM    = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   ir;
    logic [DATA_W-1:0]   reg_a;
    logic [DATA_W-1:0]   reg_b;
    logic                carry;
    logic                zero;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W:0]     add_res;
    logic [DATA_W:0]     sub_res;
    logic                wait_expired;

    // Sum with the carry-out in the extra top bit.
    function automatic logic [DATA_W:0] alu_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Difference with the borrow (x < y) in the extra top bit.
    function automatic logic [DATA_W:0] alu_sub(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    assign opcode       = ir[DATA_W-1 -: 4];
    assign operand      = ir[ADDR_W-1:0];
    assign add_res      = alu_add(reg_a, reg_b);
    assign sub_res      = alu_sub(reg_a, reg_b);
    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign flags        = {carry, zero};
    assign mem_wdata    = acc;

    // Control FSM; the memory request lines are registered and set up on the
    // transition into FETCH or MEM so they stay stable until acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!mem_req) begin
                        // Only reached straight out of reset: launch the first fetch.
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ir       <= mem_rdata;
                        pc       <= pc + ADDR_W'(1);
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= DECODE;
                    end else if (wait_expired) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        fault   <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    // Default: next instruction fetch from the current pc.
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc;
                    state    <= FETCH;
                    case (opcode)
                        OP_LDA, OP_LDB: begin
                            mem_addr <= operand;
                            state    <= MEM;
                        end
                        OP_WRT: begin
                            mem_we   <= 1'b1;
                            mem_addr <= operand;
                            state    <= MEM;
                        end
                        OP_ADD: begin
                            acc   <= add_res[DATA_W-1:0];
                            carry <= add_res[DATA_W];
                            zero  <= (add_res[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc   <= sub_res[DATA_W-1:0];
                            carry <= sub_res[DATA_W];
                            zero  <= (sub_res[DATA_W-1:0] == '0);
                        end
                        OP_JMP: begin
                            pc       <= operand;
                            mem_addr <= operand;
                        end
                        OP_JZ: begin
                            if (zero) begin
                                pc       <= operand;
                                mem_addr <= operand;
                            end
                        end
                        OP_HLT: begin
                            mem_req <= 1'b0;
                            halted  <= 1'b1;
                            state   <= HALT;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        if (opcode == OP_LDA) reg_a <= mem_rdata;
                        if (opcode == OP_LDB) reg_b <= mem_rdata;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end else if (wait_expired) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        fault   <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT: ;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter ADDR_W, default 4: memory address and program counter width.
REQ-002 Parameter DATA_W, default 8: memory word, register A/B/ACC width; DATA_W >= ADDR_W+4 SHALL hold, else elaboration error.
REQ-003 Parameter MAX_WAIT, default 15: timeout in cycles for a memory acknowledge.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req  output  1  memory transaction request.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  output  ADDR_W  transaction address.
REQ-009 mem_wdata  output  DATA_W  write data (always ACC).
REQ-010 mem_ack  input  1  transaction complete; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  input  DATA_W  read data.
REQ-012 pc  output  ADDR_W  program counter.
REQ-013 acc  output  DATA_W  accumulator.
REQ-014 flags  output  2  {carry, zero}.
REQ-015 halted  output  1  HALT state reached.
REQ-016 fault  output  1  memory timeout occurred.

Function
REQ-017 Instruction word: opcode = mem_rdata[DATA_W-1 -: 4]; operand = mem_rdata[ADDR_W-1:0]; other bits ignored.
REQ-018 Opcodes: LDA 1000, LDB 0100, ADD 0010, SUB 0001, JMP 1001, JZ 0011, WRT 1010, HLT 1111; any other code = NOP.
REQ-019 States: FETCH, DECODE, MEM, HALT; reset state FETCH.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack latch IR, pc <= pc+1 modulo 2^ADDR_W, go DECODE.
REQ-021 DECODE, LDA/LDB/WRT: go MEM; no memory request this cycle.
REQ-022 DECODE, ADD: ACC <= (A+B) mod 2^DATA_W, carry <= carry-out, zero <= (result==0); go FETCH.
REQ-023 DECODE, SUB: ACC <= (A-B) mod 2^DATA_W, carry <= borrow (A<B), zero <= (result==0); go FETCH.
REQ-024 DECODE, JMP: pc <= operand; go FETCH.
REQ-025 DECODE, JZ: pc <= operand if zero=1, else pc unchanged; go FETCH.
REQ-026 DECODE, HLT: go HALT; DECODE, NOP: go FETCH.
REQ-027 MEM: mem_req=1, mem_addr=operand, mem_we=1 for WRT else 0; on mem_ack, LDA: A <= mem_rdata, LDB: B <= mem_rdata, WRT: write complete; go FETCH.
REQ-028 Loads and WRT SHALL NOT change ACC or flags.
REQ-029 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable from request assertion until the acknowledging cycle; a request is never withdrawn except by reset or timeout.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 Zero-wait memory (mem_ack in the same cycle as the request): ALU/jump/NOP instructions take 2 cycles; load and write instructions take 3 cycles.
REQ-032 Wait counter: counts cycles with mem_req=1 and mem_ack=0; clears on ack; reaching MAX_WAIT sets fault=1 and forces HALT.
REQ-033 HALT: mem_req=0, halted=1, all registers frozen until reset.
REQ-034 Jump to own address SHALL loop indefinitely without fault.

Reset
REQ-035 On reset, the next state SHALL be: pc=0, A=B=ACC=0, flags=00, IR=0, state FETCH, halted=0, fault=0, mem_req=0, mem_we=0, wait counter 0.
REQ-036 Reset SHALL override everything, including a pending transaction or HALT; mem_req=0 in the cycle after reset is sampled.
REQ-037 The first fetch (mem_req=1, mem_addr=0) SHALL occur in the first cycle after reset deasserts.

Verification
REQ-038 Zero-wait memory. Program LDA 6, LDB 7, ADD, WRT 8, HLT; mem[6]=0x05, mem[7]=0x03. Required: mem[8]=0x08, acc=0x08, flags=00, halted=1 after exactly 13 cycles.
REQ-039 Zero and borrow flags. A=0x03, B=0x03, SUB gives acc=0x00, zero=1, carry=0. A=0x02, B=0x03, SUB gives acc=0xFF, carry=1, zero=0.
REQ-040 JZ. JZ 0x9 with zero=1 gives pc=9. JZ 0x9 with zero=0 gives pc = JZ address+1.
REQ-041 Wait states. Delay mem_ack by 3 cycles on each transaction. Required: outputs held stable throughout, same final result as REQ-038, no fault.
REQ-042 Timeout and PC wrap. Never assert ack: fault=1 and halted=1 after MAX_WAIT cycles. NOPs through address 15 (ADDR_W=4): pc wraps to 0.
REQ-043 Reset mid-operation. Assert reset during a MEM-state write: mem_req=0 next cycle, all registers 0, and fetch restarts at address 0.
